// File: rtl/asnes_pkg.sv
// Shared encodings for the 6502-family address path: addressing modes
// (same values the opcode decoder emits) and the sequencer state set.
package asnes_pkg;

    typedef enum logic [3:0] {
        M_IMP = 4'd0,
        M_ACC = 4'd1,
        M_IMM = 4'd2,
        M_ZP  = 4'd3,
        M_ZPX = 4'd4,
        M_ZPY = 4'd5,
        M_ABS = 4'd6,
        M_ABX = 4'd7,
        M_ABY = 4'd8,
        M_NDX = 4'd9,
        M_NDY = 4'd10,
        M_IND = 4'd11,
        M_REL = 4'd12
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_LO,
        S_OP_HI,
        S_PTR_LO,
        S_PTR_HI,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/idx_add.sv
// 16-bit base plus an 8-bit index (zero- or sign-extended), flagging a change
// of the high byte; for an unsigned index that is the carry out of the low byte.
module idx_add (
    input  logic [15:0] base,
    input  logic [7:0]  idx,
    input  logic        sext,
    output logic [15:0] sum,
    output logic        page_cross
);
    logic [15:0] ext;

    assign ext        = {(sext ? {8{idx[7]}} : 8'h00), idx};
    assign sum        = base + ext;
    assign page_cross = (sum[15:8] != base[15:8]);
endmodule

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: fetches operand and pointer bytes over a
// wait-stated byte bus and returns ea, pc_next and page_cross per mode.
module ea_sequencer
    import asnes_pkg::*;
#(
    parameter int AW           = 16,
    parameter bit ZP_WRAP      = 1'b1,
    parameter bit PAGE_PENALTY = 1'b1,
    parameter bit JMP_IND_BUG  = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               locked,
    input  logic                               start,
    input  logic [3:0]                         mode,
    input  logic [AW-1:0]                      pc_in,
    input  logic [7:0]                         x,
    input  logic [7:0]                         y,
    input  logic [((AW > 16) ? AW-16 : 1)-1:0] bank,
    output logic [AW-1:0]                      mem_addr,
    output logic                               mem_req,
    input  logic                               mem_rdy,
    input  logic [7:0]                         mem_rdata,
    output logic                               busy,
    output logic                               done,
    output logic [AW-1:0]                      ea,
    output logic [AW-1:0]                      pc_next,
    output logic                               page_cross
);
    localparam int BW = (AW > 16) ? AW - 16 : 1;

    state_e        state;
    mode_e         mode_r;
    logic [AW-1:0] pc_r;
    logic [BW-1:0] bank_r;
    logic [7:0]    x_r, y_r, op_lo, ptr_lo;

    logic [AW-1:0] base1, rel_ea;
    logic [7:0]    idx, lo_sel, zp_idx, ndx_p, nxt_lo;
    logic [8:0]    zp_sum;
    logic [15:0]   zp_ea, nxt_ptr, ix_sum, rel_sum;
    logic          ix_pc, rel_pc;

    function automatic logic [AW-1:0] with_bank(input logic [BW-1:0] b, input logic [15:0] a);
        logic [AW-1:0] r;
        r = AW'(a);
        if (AW > 16) r = r | (AW'(b) << 16);
        return r;
    endfunction

    assign base1  = pc_r + AW'(1);
    assign idx    = (mode_r == M_ABX) ? x_r : y_r;
    assign lo_sel = (state == S_OP_HI) ? op_lo : ptr_lo;

    idx_add u_ix  (.base({mem_rdata, lo_sel}), .idx(idx), .sext(1'b0),
                   .sum(ix_sum), .page_cross(ix_pc));
    idx_add u_rel (.base(base1[15:0]), .idx(mem_rdata), .sext(1'b1),
                   .sum(rel_sum), .page_cross(rel_pc));

    always_comb begin
        zp_idx = 8'h00;
        if (mode_r == M_ZPX)      zp_idx = x_r;
        else if (mode_r == M_ZPY) zp_idx = y_r;
        zp_sum  = {1'b0, mem_rdata} + {1'b0, zp_idx};
        zp_ea   = ZP_WRAP ? {8'h00, zp_sum[7:0]} : {7'h00, zp_sum};
        ndx_p   = mem_rdata + x_r;
        // Second pointer byte: stays in the pointer's page except for fixed-up IND.
        nxt_lo  = mem_addr[7:0] + 8'd1;
        nxt_ptr = {mem_addr[15:8], nxt_lo};
        if (mode_r == M_IND && !JMP_IND_BUG) nxt_ptr = mem_addr[15:0] + 16'd1;
        rel_ea        = base1;
        rel_ea[15:0]  = rel_sum;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ea         <= '0;
            pc_next    <= '0;
            page_cross <= 1'b0;
        end else if (locked) begin
            case (state)
                S_IDLE: if (start) begin
                    mode_r <= mode_e'(mode);
                    pc_r   <= pc_in;
                    x_r    <= x;
                    y_r    <= y;
                    bank_r <= bank;
                    busy   <= 1'b1;
                    case (mode_e'(mode))
                        M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABX, M_ABY,
                        M_NDX, M_NDY, M_IND, M_REL: begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc_in;
                            state    <= S_OP_LO;
                        end
                        M_IMM: begin
                            ea         <= pc_in;
                            pc_next    <= pc_in + AW'(1);
                            page_cross <= 1'b0;
                            state      <= S_DONE;
                        end
                        default: begin
                            ea         <= '0;
                            pc_next    <= pc_in;
                            page_cross <= 1'b0;
                            state      <= S_DONE;
                        end
                    endcase
                end
                S_OP_LO: if (mem_rdy) begin
                    op_lo <= mem_rdata;
                    case (mode_r)
                        M_ZP, M_ZPX, M_ZPY: begin
                            ea         <= AW'(zp_ea);
                            pc_next    <= base1;
                            page_cross <= 1'b0;
                            mem_req    <= 1'b0;
                            state      <= S_DONE;
                        end
                        M_REL: begin
                            ea         <= rel_ea;
                            pc_next    <= base1;
                            page_cross <= rel_pc;
                            mem_req    <= 1'b0;
                            state      <= S_DONE;
                        end
                        M_NDX: begin
                            mem_addr <= AW'(ndx_p);
                            state    <= S_PTR_LO;
                        end
                        M_NDY: begin
                            mem_addr <= AW'(mem_rdata);
                            state    <= S_PTR_LO;
                        end
                        default: begin
                            mem_addr <= pc_r + AW'(1);
                            state    <= S_OP_HI;
                        end
                    endcase
                end
                S_OP_HI: if (mem_rdy) begin
                    if (mode_r == M_IND) begin
                        mem_addr <= AW'({mem_rdata, op_lo});
                        state    <= S_PTR_LO;
                    end else begin
                        pc_next <= pc_r + AW'(2);
                        mem_req <= 1'b0;
                        if (mode_r == M_ABS) begin
                            ea         <= with_bank(bank_r, {mem_rdata, op_lo});
                            page_cross <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            ea         <= with_bank(bank_r, ix_sum);
                            page_cross <= ix_pc;
                            state      <= (PAGE_PENALTY && ix_pc) ? S_FIX : S_DONE;
                        end
                    end
                end
                S_PTR_LO: if (mem_rdy) begin
                    ptr_lo   <= mem_rdata;
                    mem_addr <= AW'(nxt_ptr);
                    state    <= S_PTR_HI;
                end
                S_PTR_HI: if (mem_rdy) begin
                    mem_req <= 1'b0;
                    pc_next <= (mode_r == M_IND) ? pc_r + AW'(2) : base1;
                    if (mode_r == M_NDY) begin
                        ea         <= with_bank(bank_r, ix_sum);
                        page_cross <= ix_pc;
                        state      <= (PAGE_PENALTY && ix_pc) ? S_FIX : S_DONE;
                    end else begin
                        ea         <= with_bank(bank_r, {mem_rdata, ptr_lo});
                        page_cross <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_FIX: state <= S_DONE;
                // First DONE cycle raises the strobe, second retires the sequence.
                S_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer: one instance with the NMOS indirect-jump
// quirk, one without, both sharing the same byte memory and handshake.
module tb_ea_sequencer;
    import asnes_pkg::*;

    logic        clock = 1'b0;
    logic        reset, locked, start, mem_rdy;
    logic [3:0]  mode;
    logic [15:0] pc_in;
    logic [7:0]  x, y;
    logic [0:0]  bank;

    logic [15:0] mem_addr, ea, pc_next, mem_addr2, ea2, pc_next2;
    logic        mem_req, busy, done, page_cross;
    logic        mem_req2, busy2, done2, page_cross2;
    logic [7:0]  mem_rdata, mem_rdata2;
    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clock = ~clock;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];

    ea_sequencer #(.AW(16), .ZP_WRAP(1'b1), .PAGE_PENALTY(1'b1), .JMP_IND_BUG(1'b1)) dut (
        .clock(clock), .reset(reset), .locked(locked), .start(start), .mode(mode),
        .pc_in(pc_in), .x(x), .y(y), .bank(bank),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .ea(ea), .pc_next(pc_next), .page_cross(page_cross)
    );

    ea_sequencer #(.AW(16), .ZP_WRAP(1'b1), .PAGE_PENALTY(1'b1), .JMP_IND_BUG(1'b0)) dut_fix (
        .clock(clock), .reset(reset), .locked(locked), .start(start), .mode(mode),
        .pc_in(pc_in), .x(x), .y(y), .bank(bank),
        .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata2),
        .busy(busy2), .done(done2), .ea(ea2), .pc_next(pc_next2), .page_cross(page_cross2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Launch one sequence with the bus always ready; returns start-to-done edges.
    task automatic run(input logic [3:0] m, input logic [15:0] pc, input logic [7:0] xi,
                       input logic [7:0] yi, output int cycles);
        mode = m; pc_in = pc; x = xi; y = yi; start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic retire(input string tag);
        tick();
        check({tag, "_done_low"}, 16'(done), 16'd0);
        check({tag, "_busy_low"}, 16'(busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1; locked = 1'b1; start = 1'b0; mem_rdy = 1'b1;
        mode = 4'd0; pc_in = 16'h0; x = 8'h0; y = 8'h0; bank = 1'b0;
        tick(); tick();
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_ea", ea, 16'h0000);
        check("rst_pc_next", pc_next, 16'h0000);
        check("rst_page_cross", 16'(page_cross), 16'd0);
        reset = 1'b0;
        tick();

        // ABX across a page: FIX cycle added
        mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;
        run(M_ABX, 16'h0200, 8'h20, 8'h00, lat);
        check("abx_lat", 16'(lat), 16'd4);
        check("abx_ea", ea, 16'h1310);
        check("abx_pc", 16'(page_cross), 16'd1);
        check("abx_pc_next", pc_next, 16'h0202);
        retire("abx");
        run(M_ABX, 16'h0200, 8'h05, 8'h00, lat);
        check("abx2_lat", 16'(lat), 16'd3);
        check("abx2_ea", ea, 16'h12F5);
        check("abx2_pc", 16'(page_cross), 16'd0);
        retire("abx2");

        mem[16'h0900] = 8'h34; mem[16'h0901] = 8'h12;
        run(M_ABS, 16'h0900, 8'h77, 8'h77, lat);
        check("abs_lat", 16'(lat), 16'd3);
        check("abs_ea", ea, 16'h1234);
        check("abs_pc_next", pc_next, 16'h0902);
        retire("abs");

        // NDX pointer wraps from 0xFF+1 to 0x00; 0x0100 must not be read
        mem[16'h0300] = 8'hFF; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        mem[16'h0100] = 8'hEE;
        run(M_NDX, 16'h0300, 8'h01, 8'h00, lat);
        check("ndx_lat", 16'(lat), 16'd4);
        check("ndx_ea", ea, 16'h1234);
        check("ndx_pc_next", pc_next, 16'h0301);
        retire("ndx");

        mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h30;
        mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h40;
        run(M_IND, 16'h0400, 8'h00, 8'h00, lat);
        check("ind_lat", 16'(lat), 16'd5);
        check("ind_ea_bug", ea, 16'h5080);
        check("ind_ea_fixed", ea2, 16'h4080);
        check("ind_done_fixed", 16'(done2), 16'd1);
        check("ind_pc_next", pc_next, 16'h0402);
        check("ind_pc_next_fixed", pc_next2, 16'h0402);
        check("ind_cross_fixed", 16'(page_cross2), 16'd0);
        retire("ind");
        check("ind_busy_fixed", 16'(busy2), 16'd0);
        check("ind_req_fixed", 16'(mem_req2), 16'd0);

        mem[16'h10FE] = 8'h85;
        run(M_REL, 16'h10FE, 8'h00, 8'h00, lat);
        check("rel_lat", 16'(lat), 16'd2);
        check("rel_ea", ea, 16'h1084);
        check("rel_pc_next", pc_next, 16'h10FF);
        check("rel_pc", 16'(page_cross), 16'd0);
        retire("rel");
        mem[16'h10FE] = 8'h01;
        run(M_REL, 16'h10FE, 8'h00, 8'h00, lat);
        check("rel2_ea", ea, 16'h1100);
        check("rel2_pc", 16'(page_cross), 16'd1);
        retire("rel2");

        mem[16'h0800] = 8'h50; mem[16'h0050] = 8'hF0; mem[16'h0051] = 8'h12;
        run(M_NDY, 16'h0800, 8'h00, 8'h20, lat);
        check("ndy_lat", 16'(lat), 16'd5);
        check("ndy_ea", ea, 16'h1310);
        check("ndy_pc", 16'(page_cross), 16'd1);
        check("ndy_pc_next", pc_next, 16'h0801);
        retire("ndy");

        run(M_IMP, 16'h0A00, 8'h00, 8'h00, lat);
        check("imp_lat", 16'(lat), 16'd1);
        check("imp_ea", ea, 16'h0000);
        check("imp_pc_next", pc_next, 16'h0A00);
        retire("imp");

        // ZPX with 3 not-ready cycles, then 2 locked-out cycles, start pulsed while busy
        mem[16'h0500] = 8'hF0;
        mode = M_ZPX; pc_in = 16'h0500; x = 8'h20; y = 8'h00; start = 1'b1;
        tick();
        start = 1'b0; lat = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rdy = 1'b0;
            start   = (i == 1);
            if (i == 1) begin mode = M_IMM; pc_in = 16'h0777; end
            tick(); lat++;
            check("zpx_stall_addr", mem_addr, 16'h0500);
            check("zpx_stall_req", 16'(mem_req), 16'd1);
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rdy = 1'b1; locked = 1'b0;
            tick(); lat++;
            check("zpx_lock_addr", mem_addr, 16'h0500);
            check("zpx_lock_req", 16'(mem_req), 16'd1);
        end
        locked = 1'b1;
        while (!done && lat < 60) begin
            tick(); lat++;
        end
        check("zpx_lat", 16'(lat), 16'd7);
        check("zpx_ea", ea, 16'h0010);
        check("zpx_pc_next", pc_next, 16'h0501);
        retire("zpx");

        // Reset while NDY is fetching its high pointer byte
        mem[16'h0600] = 8'h40;
        mode = M_NDY; pc_in = 16'h0600; x = 8'h00; y = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("ndy_rst_ptr_hi_addr", mem_addr, 16'h0041);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_req", 16'(mem_req), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_ea", ea, 16'h0000);
        tick(); tick();
        check("abort_no_done", 16'(done), 16'd0);
        run(M_IMM, 16'h0700, 8'h00, 8'h00, lat);
        check("imm_lat", 16'(lat), 16'd1);
        check("imm_ea", ea, 16'h0700);
        check("imm_pc_next", pc_next, 16'h0701);
        retire("imm");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
